cube_root_seq: RTL and testbench

- Parametrised sequential integer cube root: y_bo = floor(cbrt(x_bi)) for an unsigned WIDTH-bit operand.
- Successor to the fixed 8-bit cube-root unit. Adds a generic WIDTH, a start/busy/done handshake with fixed latency, async active-low reset, and an optional remainder output.
- Sits in the arithmetic library beside the sequential multiplier. It is driven by a controller that pulses start_i and waits on done_o.

---
 rtl/arith_pkg.sv | 17 +
 rtl/cube_root_seq_mul_shift_add.sv | 55 +++++
 rtl/cube_root_seq.sv | 130 +++++++++++++
 tb/tb_cube_root_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the iterative root units: FSM state encoding and width helpers.
package arith_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MUL,
        CMP,
        DONE
    } cbrt_state_t;

    // Cube-root iteration count, which is also the result width.
    function automatic int cbrt_iters(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cube_root_seq_mul_shift_add.sv
// Fixed-latency shift-add multiplier: p = a*b after exactly N steps following load.
module mul_shift_add
    import arith_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic [2*N:0]   p
);

    localparam int PW = 2 * N + 1;
    localparam int KW = $clog2(N + 1);

    logic [PW-1:0] r_a;
    logic [PW-1:0] r_p;
    logic [N-1:0]  r_b;
    logic [KW-1:0] r_cnt;
    logic          r_busy;

    // No early exit on b==0: the caller relies on a constant N-cycle schedule.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a    <= '0;
            r_p    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (load) begin
            r_a    <= PW'(a);
            r_b    <= b;
            r_p    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_b[0]) begin
                r_p <= r_p + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + KW'(1);
            if (r_cnt == KW'(N - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign p    = r_p;

endmodule

// File: rtl/cube_root_seq.sv
// Sequential integer cube root y = floor(cbrt(x)); define CBRT_REM_EN to add rem_bo = x - y^3.
// States: IDLE wait start | SHIFT y<<=1, load mul | MUL N-cycle y'(y'+1) | CMP trial subtract | DONE publish
module cube_root_seq
    import arith_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int N     = cbrt_iters(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_bi,
    output logic             busy_o,
    output logic             done_o,
`ifdef CBRT_REM_EN
    output logic [WIDTH-1:0] rem_bo,
`endif
    output logic [N-1:0]     y_bo
);

    localparam int S0 = 3 * (N - 1);
    localparam int PW = 2 * N + 1;
    localparam int CW = WIDTH + 2 * N + 3;
    localparam int SW = 6;
    localparam int KW = $clog2(N + 1);

    cbrt_state_t      r_state;
    logic [WIDTH-1:0] r_x;
    logic [N-1:0]     r_y;
    logic [SW-1:0]    r_s;
    logic [KW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_y_out;
`ifdef CBRT_REM_EN
    logic [WIDTH-1:0] r_rem;
`endif

    logic [N-1:0]  w_y_sh;
    logic          w_load;
    logic          w_mul_busy;
    logic [PW-1:0] w_p;
    logic [CW-1:0] w_b;
    logic [CW-1:0] w_x_ext;

    assign w_y_sh  = r_y << 1;
    assign w_load  = (r_state == SHIFT);
    // (3p+1) << s, wide enough that neither the sum nor the shift truncates
    assign w_b     = (CW'(w_p) + (CW'(w_p) << 1) + CW'(1)) << r_s;
    assign w_x_ext = CW'(r_x);

    mul_shift_add #(.N(N)) u_mul (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (w_load),
        .a      (w_y_sh),
        .b      (w_y_sh + N'(1)),
        .busy   (w_mul_busy),
        .p      (w_p)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y_out <= '0;
`ifdef CBRT_REM_EN
            r_rem   <= '0;
`endif
        end else begin
            r_busy <= (r_state != IDLE);
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_x     <= x_bi;
                        r_y     <= '0;
                        r_s     <= SW'(S0);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_y     <= w_y_sh;
                    r_cnt   <= '0;
                    r_state <= MUL;
                end
                MUL: begin
                    r_cnt <= r_cnt + KW'(1);
                    if (r_cnt == KW'(N - 1) || !w_mul_busy) begin
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    if (w_x_ext >= w_b) begin
                        r_x <= r_x - w_b[WIDTH-1:0];
                        r_y <= r_y + N'(1);
                    end
                    if (r_s == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_s     <= r_s - SW'(3);
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_y_out <= r_y;
`ifdef CBRT_REM_EN
                    r_rem   <= r_x;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign y_bo   = r_y_out;
`ifdef CBRT_REM_EN
    assign rem_bo = r_rem;
`endif

endmodule

// File: tb/tb_cube_root_seq.sv
// Bench for cube_root_seq at WIDTH=8 and WIDTH=16 against an arithmetic cube-root model.
module tb_cube_root_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  x8;
    logic [15:0] x16;
    logic        busy8, done8, busy16, done16;
    logic [2:0]  y8;
    logic [5:0]  y16;
`ifdef CBRT_REM_EN
    logic [7:0]  rem8;
    logic [15:0] rem16;
`endif

    cube_root_seq #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start8),
        .x_bi    (x8),
        .busy_o  (busy8),
        .done_o  (done8),
`ifdef CBRT_REM_EN
        .rem_bo  (rem8),
`endif
        .y_bo    (y8)
    );

    cube_root_seq #(.WIDTH(16)) u_dut16 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start16),
        .x_bi    (x16),
        .busy_o  (busy16),
        .done_o  (done16),
`ifdef CBRT_REM_EN
        .rem_bo  (rem16),
`endif
        .y_bo    (y16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit sel16    = 1'b0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_cbrt(input longint x);
        longint y = 0;
        while ((y + 1) * (y + 1) * (y + 1) <= x) y++;
        return y;
    endfunction

    function automatic logic obs_done();
        return sel16 ? done16 : done8;
    endfunction

    function automatic logic obs_busy();
        return sel16 ? busy16 : busy8;
    endfunction

    function automatic longint obs_y();
        return sel16 ? longint'(y16) : longint'(y8);
    endfunction

`ifdef CBRT_REM_EN
    function automatic longint obs_rem();
        return sel16 ? longint'(rem16) : longint'(rem8);
    endfunction
`endif

    task automatic drive_start(input bit v);
        if (sel16) start16 = v;
        else       start8  = v;
    endtask

    task automatic set_x(input longint x);
        if (sel16) x16 = x[15:0];
        else       x8  = x[7:0];
    endtask

    // One operation: optionally re-pulse start with another operand mid-flight.
    task automatic run_op(input longint x, input bit poke);
        longint ey      = ref_cbrt(x);
        int     lat_exp = sel16 ? 49 : 16;
        int     lat     = 0;
        int     pulses  = 0;
        @(negedge clk);
        set_x(x);
        drive_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_start(1'b0);
        for (int c = 1; c <= lat_exp + 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check_val($sformatf("busy_rise x=%0d", x), obs_busy(), 1);
            if (poke && c == 4) begin
                set_x(x ^ 'h35);
                drive_start(1'b1);
            end
            if (poke && c == 5) drive_start(1'b0);
            if (obs_done()) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c;
                    check_val($sformatf("y x=%0d", x), obs_y(), ey);
`ifdef CBRT_REM_EN
                    check_val($sformatf("rem x=%0d", x), obs_rem(), x - ey * ey * ey);
`endif
                end
            end
        end
        check_val($sformatf("latency x=%0d", x), lat, lat_exp);
        check_val($sformatf("done_pulses x=%0d", x), pulses, 1);
        check_val($sformatf("busy_fall x=%0d", x), obs_busy(), 0);
    endtask

    initial begin
        longint xs[3];
        int     k, cyc, last, stray;

        rst_n   = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        x8      = '0;
        x16     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy8", busy8, 0);
        check_val("rst_done8", done8, 0);
        check_val("rst_y8", y8, 0);
        check_val("rst_busy16", busy16, 0);
        check_val("rst_y16", y16, 0);
`ifdef CBRT_REM_EN
        check_val("rst_rem8", rem8, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        sel16 = 1'b0;
        run_op(27, 1'b0);
        run_op(26, 1'b0);
        run_op(0, 1'b0);
        run_op(1, 1'b0);
        run_op(255, 1'b0);
        run_op(100, 1'b1);

        for (int v = 0; v < 256; v++) run_op(v, 1'b0);

        sel16 = 1'b1;
        run_op(65535, 1'b0);
        run_op(64000, 1'b0);
        run_op(12345, 1'b1);
        for (int i = 0; i < 30; i++) run_op($urandom_range(0, 65535), 1'b0);

        // Reset during MUL: outputs clear at once, no stale completion follows.
        sel16 = 1'b0;
        run_op(255, 1'b0);
        @(negedge clk);
        x8     = 8'd100;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_y8", y8, 0);
        check_val("midrst_busy8", busy8, 0);
        check_val("midrst_done8", done8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done8) stray++;
        end
        check_val("midrst_stray_done", stray, 0);
        run_op(8, 1'b0);

        // Held start: three back-to-back operations.
        xs[0] = 27;
        xs[1] = 200;
        xs[2] = 64;
        @(negedge clk);
        x8     = xs[0][7:0];
        start8 = 1'b1;
        @(posedge clk);
        k    = 0;
        cyc  = 0;
        last = 0;
        while (k < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done8) begin
                check_val($sformatf("held_y op%0d", k), y8, ref_cbrt(xs[k]));
                if (k == 0) check_val("held_first_lat", cyc, 16);
                else        check_val($sformatf("held_gap op%0d", k), cyc - last, 17);
                last = cyc;
                k++;
                if (k < 3) x8 = xs[k][7:0];
                else       start8 = 1'b0;
            end
        end
        check_val("held_ops", k, 3);
        repeat (3) @(posedge clk);
        #1;
        check_val("held_idle_busy", busy8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
